// File: rtl/note_stream_gen.sv
// Scrolling target stream for one bongo lane: beat-pattern spawns, per-step scroll,
// head-of-FIFO position to the hit detector, hit/miss retirement and song sequencing.
module note_stream_gen #(
    parameter logic [8:0]  SPAWN_X    = 9'd300,
    parameter logic [19:0] TICK_DIV   = 20'd416667,
    parameter logic [7:0]  BEAT_TICKS = 8'd40,
    parameter logic [15:0] PATTERN    = 16'hA5A5,
    parameter logic [7:0]  SONG_BEATS = 8'd64,
    parameter int          DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       enable,
    input  logic       hit,
    output logic [8:0] stream,
    output logic       miss,
    output logic       overflow,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic       done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [19:0]      tick_cnt;
    logic [7:0]       beat_cnt, beat_idx;
    logic             hit_q;
    logic [8:0]       mem     [DEPTH];
    logic [8:0]       mem_nxt [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    logic active, step, boundary, last_beat, spawn;
    logic hit_pop, miss_pop, pop, push, drop;

    always_comb begin
        active    = ((state == RUN) || (state == DRAIN)) && enable;
        step      = active && (tick_cnt == TICK_DIV - 20'd1);
        boundary  = step && (beat_cnt == BEAT_TICKS - 8'd1);
        last_beat = boundary && (beat_idx == SONG_BEATS - 8'd1);
        spawn     = boundary && (state == RUN) && PATTERN[beat_idx[3:0]];
        hit_pop   = hit && !hit_q && (count != '0);
        // A hit edge on the head takes priority over it scrolling off
        miss_pop  = step && (count != '0) && (mem[rd_ptr] == 9'd0) && !hit_pop;
        pop       = hit_pop || miss_pop;
        push      = spawn && ((count != FULL) || pop);
        drop      = spawn && !push;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)         state_nxt = RUN;
            RUN:     if (last_beat)      state_nxt = DRAIN;
            DRAIN:   if (count == '0)    state_nxt = DONE;
            DONE:    if (!enable)        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Stale slots also decrement; they are overwritten before they become live again
    always_comb begin
        mem_nxt = mem;
        if (step)
            for (int i = 0; i < DEPTH; i++) mem_nxt[i] = mem[i] - 9'd1;
        if (push) mem_nxt[wr_ptr] = SPAWN_X;
        rd_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            beat_cnt   <= '0;
            beat_idx   <= '0;
            hit_q      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            stream     <= 9'h1FF;
            miss       <= 1'b0;
            overflow   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state  <= state_nxt;
            hit_q  <= hit;
            mem    <= mem_nxt;
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= count_nxt;
            stream <= (count_nxt == '0) ? 9'h1FF : mem_nxt[rd_nxt];
            miss     <= miss_pop;
            overflow <= drop;
            if (hit_pop && hit_count != 8'hFF)   hit_count  <= hit_count + 8'd1;
            if (miss_pop && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            if (state == IDLE) begin
                tick_cnt <= '0;
                beat_cnt <= '0;
                beat_idx <= '0;
            end else if (active) begin
                tick_cnt <= step ? 20'd0 : tick_cnt + 20'd1;
                if (boundary) begin
                    beat_cnt <= '0;
                    beat_idx <= beat_idx + 8'd1;
                end else if (step) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    assign done = (state == DONE);
endmodule
